// File: rtl/gray_conv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gray_conv_pkg
// Purpose  : Shared FSM state encoding and job mode constants for the
//            Gray-code conversion arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package gray_conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_B2G = 1'b0;
    localparam logic MODE_G2B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/gray_conv_unit.sv
`default_nettype none
// ============================================================================
// Module   : gray_conv_unit
// Purpose  : Shared converter: single-cycle binary-to-Gray, or bit-serial
//            MSB-first Gray-to-binary over N cycles. Start in, done out.
// Revision : 1.0 - initial release
// ============================================================================
module gray_conv_unit
    import gray_conv_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic         i_mode,
    input  logic [N-1:0] i_din,
    output logic         o_done,
    output logic [N-1:0] o_dout
);

    localparam int              c_KW   = $clog2(N);
    localparam logic [c_KW-1:0] c_KTOP = c_KW'(N - 1);

    logic            r_active;
    logic            r_mode;
    logic [N-1:0]    r_op;
    logic [N-1:0]    r_b;
    logic            r_run;
    logic [c_KW-1:0] r_k;

    logic            w_bit;
    logic [N-1:0]    w_b2g;
    logic [N-1:0]    w_g2b;

    // r_run carries b[k+1]; it starts at 0 so the MSB step yields b[N-1] = g[N-1]
    assign w_bit  = r_run ^ r_op[r_k];
    assign w_b2g  = {r_op[N-1], r_op[N-1:1] ^ r_op[N-2:0]};
    assign w_g2b  = r_b | {{(N-1){1'b0}}, w_bit};
    assign o_done = r_active & ((r_mode == MODE_B2G) | (r_k == '0));
    assign o_dout = (r_mode == MODE_B2G) ? w_b2g : w_g2b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_mode   <= MODE_B2G;
            r_op     <= '0;
            r_b      <= '0;
            r_run    <= 1'b0;
            r_k      <= c_KTOP;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_mode   <= i_mode;
            r_op     <= i_din;
            r_b      <= '0;
            r_run    <= 1'b0;
            r_k      <= c_KTOP;
        end else if (r_active) begin
            if (o_done) begin
                r_active <= 1'b0;
            end else begin
                r_b[r_k] <= w_bit;
                r_run    <= w_bit;
                r_k      <= r_k - c_KW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gray_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gray_conv_arbiter
// Purpose  : Two-requester round-robin front end for the shared Gray-code
//            converter, with a tagged, back-pressured response channel.
//            Define GCA_FIXED_PRIO_EN for fixed priority (requester 0 wins).
// Revision : 1.0 - initial release
// ============================================================================
module gray_conv_arbiter
    import gray_conv_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [1:0]   req_mode,
    input  logic [N-1:0] req_data0,
    input  logic [N-1:0] req_data1,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_data,
    output logic         busy
);

    state_t       r_state;
    state_t       w_next;
    logic [1:0]   w_grant;
    logic [1:0]   w_ready;
    logic         w_accept;
    logic         w_acc_id;
    logic         w_acc_mode;
    logic [N-1:0] w_acc_data;
    logic         w_done;
    logic [N-1:0] w_dout;
    logic         r_rsp_id;
    logic [N-1:0] r_rsp_data;

`ifdef GCA_FIXED_PRIO_EN
    always_comb begin
        w_grant = 2'b00;
        case (req_valid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = 2'b01;
            default: w_grant = 2'b00;
        endcase
    end
`else
    logic r_last_grant;

    always_comb begin
        w_grant = 2'b00;
        case (req_valid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_acc_id;
        end
    end
`endif

    assign w_ready    = ((r_state == IDLE) && !rst) ? w_grant : 2'b00;
    assign w_accept   = |(req_valid & w_ready);
    assign w_acc_id   = w_ready[1];
    assign w_acc_mode = req_mode[w_acc_id];
    assign w_acc_data = w_acc_id ? req_data1 : req_data0;

    gray_conv_unit #(
        .N (N)
    ) u_unit (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_accept),
        .i_mode  (w_acc_mode),
        .i_din   (w_acc_data),
        .o_done  (w_done),
        .o_dout  (w_dout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_next = CONV;
            CONV:    if (w_done)    w_next = DONE;
            DONE:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_id   <= 1'b0;
            r_rsp_data <= '0;
        end else begin
            if (w_accept) begin
                r_rsp_id <= w_acc_id;
            end
            if ((r_state == CONV) && w_done) begin
                r_rsp_data <= w_dout;
            end
        end
    end

    // Outputs are forced quiet for the whole time rst is held, not just after its edge
    assign req_ready = w_ready;
    assign rsp_valid = (r_state == DONE) && !rst;
    assign rsp_id    = r_rsp_id && !rst;
    assign rsp_data  = rst ? '0 : r_rsp_data;
    assign busy      = (r_state != IDLE) && !rst;

endmodule
`default_nettype wire

// File: tb/tb_gray_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_conv_arbiter
// Purpose  : Directed, table-driven bench for gray_conv_arbiter (N=4 and N=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gray_conv_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req_valid, req_ready, req_mode;
    logic [3:0] req_data0, req_data1, rsp_data;
    logic       rsp_valid, rsp_ready, rsp_id, busy;

    logic [1:0] req_valid8, req_ready8, req_mode8;
    logic [7:0] req_data08, req_data18, rsp_data8;
    logic       rsp_valid8, rsp_ready8, rsp_id8, busy8;

    int tests = 0;
    int fails = 0;

    gray_conv_arbiter #(.N(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_mode(req_mode), .req_data0(req_data0), .req_data1(req_data1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy)
    );

    gray_conv_arbiter #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .req_valid(req_valid8), .req_ready(req_ready8),
        .req_mode(req_mode8), .req_data0(req_data08), .req_data1(req_data18),
        .rsp_valid(rsp_valid8), .rsp_ready(rsp_ready8), .rsp_id(rsp_id8),
        .rsp_data(rsp_data8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       id;
        logic       mode;
        logic [3:0] data;
        logic [3:0] exp;
        int         lat;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wait at negedges (bounded) for the N=4 response; returns cycles counted
    task automatic wait_rsp(input int start_cnt, output int cnt);
        cnt = start_cnt;
        while (!rsp_valid && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    // Caller sits at a negedge with the block IDLE and rsp_ready = 1
    task automatic run_job(input logic id, input logic mode, input logic [3:0] data,
                           input logic [3:0] exp, input int lat);
        int cnt;
        req_mode[id] = mode;
        if (id) req_data1 = data; else req_data0 = data;
        req_valid = id ? 2'b10 : 2'b01;
        #1;
        check("job_ready", {31'd0, req_ready[id]}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        req_data0 = ~req_data0;
        req_data1 = ~req_data1;
        wait_rsp(1, cnt);
        check("job_latency", cnt, lat);
        check("job_data", {28'd0, rsp_data}, {28'd0, exp});
        check("job_id", {31'd0, rsp_id}, {31'd0, id});
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin : main
        int         cnt;
        int         t;
        int         seen;
        logic [1:0] exp_g [4];
        logic [3:0] exp_d [4];

        vecs[0] = '{id: 1'b0, mode: 1'b0, data: 4'b0101, exp: 4'b0111, lat: 2};
        vecs[1] = '{id: 1'b1, mode: 1'b1, data: 4'b1001, exp: 4'b1110, lat: 5};
        vecs[2] = '{id: 1'b0, mode: 1'b0, data: 4'b0011, exp: 4'b0010, lat: 2};
        vecs[3] = '{id: 1'b1, mode: 1'b0, data: 4'b1000, exp: 4'b1100, lat: 2};
        vecs[4] = '{id: 1'b0, mode: 1'b1, data: 4'b0000, exp: 4'b0000, lat: 5};
        vecs[5] = '{id: 1'b1, mode: 1'b1, data: 4'b1111, exp: 4'b1010, lat: 5};
        vecs[6] = '{id: 1'b0, mode: 1'b0, data: 4'b1111, exp: 4'b1000, lat: 2};

        rst = 1'b1;
        req_valid = 2'b11; req_mode = 2'b00; req_data0 = 4'h0; req_data1 = 4'h0;
        rsp_ready = 1'b1;
        req_valid8 = 2'b00; req_mode8 = 2'b00; req_data08 = 8'h0; req_data18 = 8'h0;
        rsp_ready8 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {30'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        check("rst_rsp_data", {28'd0, rsp_data}, 32'd0);
        req_valid = 2'b00;
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_job(vecs[i].id, vecs[i].mode, vecs[i].data, vecs[i].exp, vecs[i].lat);
        end

        // Tie arbitration starting from a fresh reset
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
`ifdef GCA_FIXED_PRIO_EN
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
        exp_d = '{4'b0010, 4'b0010, 4'b0010, 4'b0010};
`else
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_d = '{4'b0010, 4'b1100, 4'b0010, 4'b1100};
`endif
        req_mode = 2'b00; req_data0 = 4'b0011; req_data1 = 4'b1000;
        req_valid = 2'b11;
        for (int j = 0; j < 4; j++) begin
            #1;
            t = 0;
            while (req_ready == 2'b00 && t < 20) begin
                @(negedge clk);
                #1;
                t++;
            end
            check("tie_grant", {30'd0, req_ready}, {30'd0, exp_g[j]});
            @(posedge clk);
            @(negedge clk);
            wait_rsp(1, cnt);
            check("tie_data", {28'd0, rsp_data}, {28'd0, exp_d[j]});
            check("tie_id", {31'd0, rsp_id}, {31'd0, exp_g[j][1]});
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 2'b00;
        @(negedge clk);

        // Response back-pressure
        rsp_ready = 1'b0;
        req_mode = 2'b00; req_data0 = 4'b0101; req_data1 = 4'b1000;
        req_valid = 2'b01;
        #1;
        check("stall_ready0", {30'd0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b10;
        wait_rsp(1, cnt);
        check("stall_latency", cnt, 2);
        for (int c = 0; c < 10; c++) begin
            check("stall_valid", {31'd0, rsp_valid}, 32'd1);
            check("stall_data", {28'd0, rsp_data}, 32'h7);
            check("stall_id", {31'd0, rsp_id}, 32'd0);
            check("stall_req_ready", {30'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("stall_release_ready", {30'd0, req_ready}, 32'd2);
        check("stall_release_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        wait_rsp(1, cnt);
        check("stall_next_data", {28'd0, rsp_data}, 32'hC);
        check("stall_next_id", {31'd0, rsp_id}, 32'd1);
        @(posedge clk);
        @(negedge clk);

        // Reset in cycle 2 of a G2B job from requester 0
        req_mode = 2'b01; req_data0 = 4'b1001;
        req_valid = 2'b01;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        check("abort_busy_c1", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_during_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_during_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_after_busy", {31'd0, busy}, 32'd0);
        check("abort_after_valid", {31'd0, rsp_valid}, 32'd0);
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("abort_no_response", seen, 0);
        req_mode = 2'b00; req_data0 = 4'b0011; req_data1 = 4'b1000;
        req_valid = 2'b11;
        #1;
        check("abort_tie_grant", {30'd0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        wait_rsp(1, cnt);
        check("abort_tie_data", {28'd0, rsp_data}, 32'h2);
        @(posedge clk);
        @(negedge clk);

        // Wider instance: G2B of all ones
        req_mode8 = 2'b01; req_data08 = 8'hFF;
        req_valid8 = 2'b01;
        #1;
        check("n8_ready", {30'd0, req_ready8}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid8 = 2'b00;
        req_data08 = 8'h00;
        cnt = 1;
        while (!rsp_valid8 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("n8_latency", cnt, 9);
        check("n8_data", {24'd0, rsp_data8}, 32'hAA);
        check("n8_id", {31'd0, rsp_id8}, 32'd0);
        @(posedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gray_conv_arbiter.md
# gray_conv_arbiter

Shares a single Gray-code conversion unit between two requesters. It accepts binary-to-Gray (B2G) or Gray-to-binary (G2B) jobs over valid/ready, arbitrates between requesters round-robin, and sequences the conversion. B2G takes one cycle; G2B is resolved bit-serially, MSB first. Each result is returned on a single response channel, tagged with the requester ID. It sits between pointer/counter logic and the shared converter datapath.

## Interface
- N, 4: data width in bits, N ≥ 2.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester job valid.
- req_ready  out  2  per-requester grant; at most one bit high.
- req_mode  in  2  per-requester mode: 0 = B2G, 1 = G2B.
- req_data0, req_data1  in  N each  operands for requester 0 and requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  1  requester that issued the job.
- rsp_data  out  N  converted value.
- busy  out  1  high whenever the block is not IDLE.

## Operation
- States: IDLE, CONV, DONE.
- **IDLE**
  - req_ready[i] = grant[i]; this is combinational from req_valid and the last-grant pointer.
  - A handshake (req_valid[i] & req_ready[i]) captures the operand, mode and ID, then moves to CONV.
- **Arbitration**
  - One requester valid: that requester is granted.
  - Both valid: the requester not granted last wins.
  - last_grant updates only on a handshake; it resets to 1, so requester 0 wins the first tie.
- **CONV, B2G**
  - One cycle: result = {d[N-1], d[N-1:1] ^ d[N-2:0]}.
- **CONV, G2B**
  - N cycles, bit index k runs N-1 down to 0.
  - b[N-1] = g[N-1]; then b[k] = b[k+1] ^ g[k].
  - The index counter is ceil(log2 N) bits wide and does not wrap past 0.
- **DONE**
  - rsp_valid = 1, with rsp_data and rsp_id held stable until rsp_ready.
  - On rsp_ready: go to IDLE.
  - No request is accepted in DONE or CONV; req_ready = 0 in both.
- Operands are registered at accept, so requesters may change req_data after the handshake.
- Reset, including reset in the middle of a job:
  - state goes to IDLE; the pending job is discarded and no response is issued;
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0, busy = 0, req_ready = 0 while rst is high;
  - last_grant = 1.

## Timing
- Handshake at edge 0.
  - B2G: CONV during cycle 1; rsp_valid high from cycle 2.
  - G2B: CONV during cycles 1..N; rsp_valid high from cycle N+1.
- Response handshake at edge t puts the block in IDLE in cycle t+1; the next request can be accepted in cycle t+1. There is no DONE→CONV bypass.
- Throughput at full rate: one job per 3 cycles (B2G) or per N+2 cycles (G2B).
- rsp_ready held low stalls the block indefinitely in DONE. Outputs stay stable and requests remain blocked.

## Configuration
- GCA_FIXED_PRIO_EN
  - Defined: fixed priority, requester 0 always wins a tie; the last_grant register is not built.
  - Undefined: round-robin as described above.

## Structure
- Package gray_conv_pkg holds:
  - the state enum (IDLE/CONV/DONE);
  - mode constants MODE_B2G = 1'b0 and MODE_G2B = 1'b1.
- Sub-module gray_conv_unit: the shared converter. It takes the operand and mode with a start pulse and returns the result with a done pulse; it owns the G2B bit counter.
- The top level holds the arbiter, FSM and response register.

## Test plan
- Requester 0 sends B2G 4'b0101 → rsp_data = 4'b0111, rsp_id = 0, rsp_valid two cycles after accept.
- Requester 1 sends G2B 4'b1001 → rsp_data = 4'b1110, rsp_id = 1, rsp_valid five cycles after accept (N = 4).
- Both requesters continuously valid (B2G, operands 0011 / 1000):
  - grants alternate 0, 1, 0, 1;
  - results 0010 / 1100;
  - with GCA_FIXED_PRIO_EN defined, only requester 0 is served.
- Hold rsp_ready = 0 for 10 cycles after a result:
  - rsp_data and rsp_id stay stable;
  - req_ready = 0 throughout;
  - the next accept happens in the cycle after rsp_ready rises.
- Assert rst during cycle 2 of a G2B job:
  - the next cycle shows IDLE, busy = 0, rsp_valid = 0;
  - no response ever appears for the aborted job;
  - the next tie is granted to requester 0.
- N = 8, G2B 8'b11111111 → 8'b10101010, valid nine cycles after accept.
